// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter
//   Shares a two-digit, active-low seven-segment display between two
//   requesters. The digit-scan timebase is generated internally from CLK.
//   Ownership is granted round-robin with a minimum dwell time. The owner
//   changes only on frame boundaries, so both digits always come from the
//   same source.
//
// Parameters
//   SCAN_DIV : CLK cycles per digit slot (>= 2)
//   DWELL    : minimum frames an owner keeps the display under contention (>= 1)
//
// Ports
//   CLK    in   system clock, rising edge
//   RST_N  in   synchronous active-low reset
//   REQ    in   [1:0] request levels, sampled only at frame end
//   DATA0  in   [7:0] requester 0 value, [3:0] right digit, [7:4] left digit
//   DATA1  in   [7:0] requester 1 value, same format
//   GNT    out  [1:0] one-hot, one-cycle pulse when ownership is granted
//   OWNER  out  [1:0] one-hot current owner, 00 when idle
//   COM    out  [1:0] digit enables, active-low; [0] = right, [1] = left
//   SEG    out  [6:0] {g,f,e,d,c,b,a}, active-low
module seg_scan_arbiter #(
    parameter int SCAN_DIV = 500,
    parameter int DWELL    = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [1:0] REQ,
    input  logic [7:0] DATA0,
    input  logic [7:0] DATA1,
    output logic [1:0] GNT,
    output logic [1:0] OWNER,
    output logic [1:0] COM,
    output logic [6:0] SEG
);

    localparam int PW  = $clog2(SCAN_DIV);
    localparam int DCW = $clog2(DWELL + 1);

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    state_t         state, state_d;
    logic [PW-1:0]  presc;
    logic           slot;
    logic           own_idx, own_d;
    logic           rr, rr_d;
    logic [DCW-1:0] dwell_cnt, dwell_d;
    logic [7:0]     disp, disp_d;

    logic           tick, fe;
    logic           grant, win;
    logic           own_req, oth_req;
    logic           slot_d;
    logic [1:0]     gnt_d, owner_d, com_d;
    logic [6:0]     seg_d;

    // Full hex glyph table, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    assign tick    = (presc == PW'(SCAN_DIV - 1));
    // A frame ends on the tick that closes the left-digit slot.
    assign fe      = tick & slot;
    assign own_req = REQ[own_idx];
    assign oth_req = REQ[~own_idx];

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state and arbitration decision; nothing moves outside frame end.
    always_comb begin
        state_d = state;
        own_d   = own_idx;
        rr_d    = rr;
        dwell_d = dwell_cnt;
        disp_d  = disp;
        grant   = 1'b0;
        win     = 1'b0;
        if (fe) begin
            case (state)
                IDLE: begin
                    if (|REQ) begin
                        grant = 1'b1;
                        // On a tie, favour whoever was not granted last.
                        win   = (REQ == 2'b11) ? ~rr : REQ[1];
                    end
                end
                OWN: begin
                    if (!own_req && oth_req) begin
                        grant = 1'b1;
                        win   = ~own_idx;
                    end else if (!own_req) begin
                        state_d = IDLE;
                    end else if (oth_req && (int'(dwell_cnt) + 1 >= DWELL)) begin
                        grant = 1'b1;
                        win   = ~own_idx;
                    end else begin
                        disp_d = own_idx ? DATA1 : DATA0;
                        if (int'(dwell_cnt) < DWELL) dwell_d = dwell_cnt + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (grant) begin
                state_d = OWN;
                own_d   = win;
                rr_d    = win;
                dwell_d = '0;
                disp_d  = win ? DATA1 : DATA0;
            end
        end
    end

    // Output decode from next-cycle values so the registered outputs change
    // on the same edge as the slot toggle or the arbitration decision.
    always_comb begin
        slot_d  = tick ? ~slot : slot;
        gnt_d   = 2'b00;
        owner_d = 2'b00;
        com_d   = 2'b11;
        seg_d   = 7'h7F;
        if (grant) gnt_d = win ? 2'b10 : 2'b01;
        if (state_d == OWN) begin
            owner_d = own_d ? 2'b10 : 2'b01;
            if (!slot_d) begin
                com_d = 2'b10;
                seg_d = glyph(disp_d[3:0]);
            end else begin
                com_d = 2'b01;
                seg_d = glyph(disp_d[7:4]);
            end
        end
    end

    // Timebase, arbitration datapath and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            presc     <= '0;
            slot      <= 1'b0;
            own_idx   <= 1'b0;
            rr        <= 1'b1;
            dwell_cnt <= '0;
            disp      <= 8'h00;
            GNT       <= 2'b00;
            OWNER     <= 2'b00;
            COM       <= 2'b11;
            SEG       <= 7'h7F;
        end else begin
            presc     <= tick ? '0 : presc + 1'b1;
            slot      <= slot_d;
            own_idx   <= own_d;
            rr        <= rr_d;
            dwell_cnt <= dwell_d;
            disp      <= disp_d;
            GNT       <= gnt_d;
            OWNER     <= owner_d;
            COM       <= com_d;
            SEG       <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Directed bench for seg_scan_arbiter with SCAN_DIV=4, DWELL=2 (frame = 8 cycles).
// Expected grants are queued when the stimulus that causes them is driven;
// a monitor pops and compares them whenever GNT pulses.
module tb_seg_scan_arbiter;

    logic       CLK;
    logic       RST_N;
    logic [1:0] REQ;
    logic [7:0] DATA0, DATA1;
    logic [1:0] GNT, OWNER, COM;
    logic [6:0] SEG;

    int checks   = 0;
    int failures = 0;
    logic [1:0] sb[$];

    seg_scan_arbiter #(.SCAN_DIV(4), .DWELL(2)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .REQ   (REQ),
        .DATA0 (DATA0),
        .DATA1 (DATA1),
        .GNT   (GNT),
        .OWNER (OWNER),
        .COM   (COM),
        .SEG   (SEG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic disp(input string tag, input logic [1:0] com, input logic [6:0] seg);
        chk({tag, "_com"}, 32'(COM), 32'(com));
        chk({tag, "_seg"}, 32'(SEG), 32'(seg));
    endtask

    // Grant scoreboard.
    always @(negedge CLK) begin
        if (GNT !== 2'b00) begin
            if (sb.size() == 0) chk("gnt_unexpected", 32'(GNT), 32'h0);
            else                chk("gnt_sb", 32'(GNT), 32'(sb.pop_front()));
        end
    end

    initial begin
        RST_N = 1'b0;
        REQ   = 2'b11;
        DATA0 = 8'h53;
        DATA1 = 8'hF0;

        // Reset held 3 cycles with both requests up.
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("rst_gnt", 32'(GNT), 32'h0);
            chk("rst_owner", 32'(OWNER), 32'h0);
            disp("rst", 2'b11, 7'h7F);
        end
        RST_N = 1'b1;
        sb.push_back(2'b01);
        step(7);
        chk("first_gnt_early", 32'(GNT), 32'h0);
        disp("idle_blank", 2'b11, 7'h7F);
        step(1);                                   // edge 8: first FE
        chk("first_gnt", 32'(GNT), 32'h1);
        chk("first_owner", 32'(OWNER), 32'h1);
        disp("own0_slot0", 2'b10, 7'h30);
        step(1);
        chk("gnt_one_cycle", 32'(GNT), 32'h0);

        // Contention: no switch at the 1st FE, switch at the 2nd.
        step(7);                                   // edge 16
        chk("cont_fe1_gnt", 32'(GNT), 32'h0);
        chk("cont_fe1_owner", 32'(OWNER), 32'h1);
        sb.push_back(2'b10);
        step(8);                                   // edge 24
        chk("cont_fe2_gnt", 32'(GNT), 32'h2);
        chk("cont_fe2_owner", 32'(OWNER), 32'h2);
        disp("own1_slot0", 2'b10, 7'h40);
        step(4);                                   // edge 28
        disp("own1_slot1", 2'b01, 7'h0E);

        // Drop and re-raise between FEs: ignored.
        REQ = 2'b00;
        step(2);
        REQ = 2'b11;
        step(2);                                   // edge 32
        chk("pulse_gnt", 32'(GNT), 32'h0);
        chk("pulse_owner", 32'(OWNER), 32'h2);

        // Release: both low -> IDLE at next FE.
        REQ = 2'b00;
        step(7);
        chk("rel_pre_owner", 32'(OWNER), 32'h2);
        step(1);                                   // edge 40
        chk("rel_owner", 32'(OWNER), 32'h0);
        chk("rel_gnt", 32'(GNT), 32'h0);
        disp("rel", 2'b11, 7'h7F);

        // Round robin: last grant was 1, so 0 wins next tie, then 1.
        REQ = 2'b11;
        sb.push_back(2'b01);
        step(8);                                   // edge 48
        chk("rr_a_gnt", 32'(GNT), 32'h1);
        disp("rr_a", 2'b10, 7'h30);
        REQ = 2'b00;
        step(8);                                   // edge 56
        chk("rr_idle_owner", 32'(OWNER), 32'h0);
        REQ = 2'b11;
        sb.push_back(2'b10);
        step(8);                                   // edge 64
        chk("rr_b_gnt", 32'(GNT), 32'h2);
        step(1);
        chk("rr_b_pulse", 32'(GNT), 32'h0);
        chk("rr_b_owner", 32'(OWNER), 32'h2);

        // Owner drops while other rises at the same FE: direct switch.
        REQ = 2'b01;
        sb.push_back(2'b01);
        step(7);                                   // edge 72
        chk("direct_gnt", 32'(GNT), 32'h1);
        chk("direct_owner", 32'(OWNER), 32'h1);
        disp("single_s0", 2'b10, 7'h30);
        step(4);                                   // edge 76
        disp("single_s1", 2'b01, 7'h12);
        step(4);                                   // edge 80
        chk("refresh_gnt", 32'(GNT), 32'h0);
        disp("single_s0b", 2'b10, 7'h30);
        step(1);
        DATA0 = 8'h00;                             // not shown until next FE
        step(3);                                   // edge 84
        disp("hold_data", 2'b01, 7'h12);
        step(4);                                   // edge 88
        disp("refresh_data", 2'b10, 7'h40);

        // Hand over to 1, then reset mid-ownership.
        REQ = 2'b10;
        sb.push_back(2'b10);
        step(8);                                   // edge 96
        chk("pre_rst_owner", 32'(OWNER), 32'h2);
        step(2);
        RST_N = 1'b0;
        REQ   = 2'b11;
        step(1);
        chk("mid_rst_owner", 32'(OWNER), 32'h0);
        chk("mid_rst_gnt", 32'(GNT), 32'h0);
        disp("mid_rst", 2'b11, 7'h7F);
        RST_N = 1'b1;
        sb.push_back(2'b01);
        step(7);
        chk("mid_rst_early", 32'(GNT), 32'h0);
        step(1);
        chk("mid_rst_gnt1", 32'(GNT), 32'h1);
        chk("mid_rst_owner1", 32'(OWNER), 32'h1);

        // Sustained contention alternates every DWELL frames.
        sb.push_back(2'b10);
        step(16);
        chk("alt_a_gnt", 32'(GNT), 32'h2);
        sb.push_back(2'b01);
        step(16);
        chk("alt_b_gnt", 32'(GNT), 32'h1);
        REQ = 2'b00;
        step(1);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
